// File: rtl/alu_execute_if.sv
// rtl/alu_execute_if.sv - operation/result handshake bundle for alu_execute
interface alu_execute_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid_i;
   logic                  in_ready_o;
   logic [3:0]            alu_ctrl_i;
   logic                  branch_i;
   logic [DATA_WIDTH-1:0] a_i;
   logic [DATA_WIDTH-1:0] b_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [DATA_WIDTH-1:0] result_o;
   logic                  zero_o;
   logic                  branch_taken_o;

   modport master (
      output in_valid_i, alu_ctrl_i, branch_i, a_i, b_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, zero_o, branch_taken_o
   );

   modport slave (
      input  in_valid_i, alu_ctrl_i, branch_i, a_i, b_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, zero_o, branch_taken_o
   );
endinterface

// File: rtl/alu_execute.sv
// rtl/alu_execute.sv - RV32I execute ALU, iterative shifter; ALU_FAST_SHIFT_EN selects a barrel shifter
module alu_execute #(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic         clk,
   input  logic         rst,
   alu_execute_if.slave bus
);
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SLL  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SLT  = 3'b101;
   localparam logic [2:0] OP_SR   = 3'b110;
   localparam logic [2:0] OP_SLTU = 3'b111;

`ifdef ALU_FAST_SHIFT_EN
   typedef enum logic {IDLE, RESP} state_t;
`else
   typedef enum logic [1:0] {IDLE, RESP, SHIFT} state_t;
`endif

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  taken_q, taken_d;
`ifndef ALU_FAST_SHIFT_EN
   logic [SHAMT_W-1:0]    cnt_q, cnt_d;
   logic                  left_q, left_d;
   logic                  arith_q, arith_d;
`endif

   logic [2:0]            op;
   logic                  f7;
   logic [SHAMT_W-1:0]    shamt;
   logic                  is_shift;
   logic [DATA_WIDTH-1:0] diff;
   logic                  eq, lt, ltu;
   logic [DATA_WIDTH-1:0] op_result;
   logic                  cond;
   logic                  in_ready, out_valid;

   assign op       = bus.alu_ctrl_i[2:0];
   assign f7       = bus.alu_ctrl_i[3];
   assign shamt    = bus.b_i[SHAMT_W-1:0];
   assign is_shift = !bus.branch_i && (op == OP_SLL || op == OP_SR);
   assign diff     = bus.a_i - bus.b_i;
   assign eq       = (bus.a_i == bus.b_i);
   assign lt       = ($signed(bus.a_i) < $signed(bus.b_i));
   assign ltu      = (bus.a_i < bus.b_i);

   // Iterative build: a shift's value here is only used for shamt 0 (result = a).
   always_comb begin
      op_result = '0;
      if (bus.branch_i) begin
         op_result = diff;
      end else begin
         case (op)
            OP_ADD:  op_result = f7 ? diff : bus.a_i + bus.b_i;
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  op_result = bus.a_i << shamt;
            OP_SR:   op_result = f7 ? DATA_WIDTH'($signed(bus.a_i) >>> shamt) : bus.a_i >> shamt;
`else
            OP_SLL:  op_result = bus.a_i;
            OP_SR:   op_result = bus.a_i;
`endif
            OP_AND:  op_result = bus.a_i & bus.b_i;
            OP_OR:   op_result = bus.a_i | bus.b_i;
            OP_XOR:  op_result = bus.a_i ^ bus.b_i;
            OP_SLT:  op_result = {{(DATA_WIDTH-1){1'b0}}, lt};
            OP_SLTU: op_result = {{(DATA_WIDTH-1){1'b0}}, ltu};
            default: op_result = '0;
         endcase
      end
   end

   always_comb begin
      cond = 1'b0;
      case (op)
         3'b000:  cond = eq;
         3'b001:  cond = !eq;
         3'b100:  cond = lt;
         3'b101:  cond = !lt;
         3'b110:  cond = ltu;
         3'b111:  cond = !ltu;
         default: cond = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      taken_d   = taken_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      cnt_d     = cnt_q;
      left_d    = left_q;
      arith_d   = arith_q;
`endif
      case (state_q)
         IDLE: in_ready = 1'b1;
         RESP: begin
            out_valid = 1'b1;
            in_ready  = bus.out_ready_i;
            if (bus.out_ready_i) state_d = IDLE;
         end
`ifndef ALU_FAST_SHIFT_EN
         SHIFT: begin
            // result_q doubles as the working register while out_valid is low
            if (left_q) result_d = {result_q[DATA_WIDTH-2:0], 1'b0};
            else        result_d = {arith_q & result_q[DATA_WIDTH-1], result_q[DATA_WIDTH-1:1]};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) state_d = RESP;
         end
`endif
         default: state_d = IDLE;
      endcase

      if (bus.in_valid_i && in_ready) begin
         result_d = op_result;
         taken_d  = bus.branch_i & cond;
         state_d  = RESP;
`ifndef ALU_FAST_SHIFT_EN
         if (is_shift && shamt != '0) begin
            result_d = bus.a_i;
            taken_d  = 1'b0;
            cnt_d    = shamt;
            left_d   = (op == OP_SLL);
            arith_d  = (op == OP_SR) && f7;
            state_d  = SHIFT;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         taken_q  <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
         cnt_q    <= '0;
         left_q   <= 1'b0;
         arith_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         taken_q  <= taken_d;
`ifndef ALU_FAST_SHIFT_EN
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         arith_q  <= arith_d;
`endif
      end
   end

`ifdef ALU_FAST_SHIFT_EN
   logic unused_shift_flag;
   assign unused_shift_flag = is_shift;
`endif

   assign bus.in_ready_o     = in_ready;
   assign bus.out_valid_o    = out_valid;
   assign bus.result_o       = result_q;
   assign bus.zero_o         = (result_q == '0);
   assign bus.branch_taken_o = taken_q;
endmodule

// File: doc/alu_execute.md
Name: alu_execute

Overview:
- Execute-stage ALU for the pipelined RV32I core; the consumer of the 4-bit ALU control code produced in decode.
- Accepts one operation per handshake and produces a registered result plus a branch-taken flag.
- Shifts run iteratively, one bit per cycle, under a small FSM. The block back-pressures the pipeline through in_ready, which the hazard unit treats as a stall.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount width taken from b_i[SHAMT_W-1:0].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid_i  in  1  operation presented.
- in_ready_o  out  1  operation accepted on an edge where in_valid_i && in_ready_o.
- alu_ctrl_i  in  4  ALU control code {funct7_bit, op[2:0]}.
- branch_i  in  1  1 = branch compare; alu_ctrl_i[2:0] is then funct3.
- a_i  in  DATA_WIDTH  operand A (rs1).
- b_i  in  DATA_WIDTH  operand B (rs2 or immediate).
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- result_o  out  DATA_WIDTH  registered result.
- zero_o  out  1  result_o == 0.
- branch_taken_o  out  1  branch condition true; 0 for non-branch operations.

Behaviour:
- Reset: state IDLE; out_valid_o=0, result_o=0, branch_taken_o=0, zero_o=1, shift counter=0. Reset mid-shift aborts the operation and discards it; nothing is output.
- Opcode map, non-branch:
  - 0000 ADD; 1000 SUB.
  - x001 SLL.
  - x101 SLT, signed, result 1/0 zero-extended.
  - x111 SLTU, unsigned.
  - x100 XOR; x011 OR; x010 AND.
  - 0110 SRL; 1110 SRA.
- Branch mode (branch_i=1): result_o = a_i - b_i, wraps mod 2^DATA_WIDTH. Taken by funct3:
  - 000 BEQ, 001 BNE.
  - 100 BLT, 101 BGE (signed).
  - 110 BLTU, 111 BGEU (unsigned).
  - 010 and 011 give taken=0.
- Arithmetic: ADD/SUB wrap with no carry or overflow output. Shift amount is b_i[SHAMT_W-1:0] only; upper bits are ignored.
- FSM states:
  - IDLE: in_ready_o=1.
    - Accept non-shift, or shift with amount 0 -> RESP.
    - Accept shift with amount k>0 -> SHIFT, counter=k.
  - SHIFT: in_ready_o=0, out_valid_o=0.
    - Each edge shifts the working register by 1 bit (SRA replicates bit DATA_WIDTH-1) and decrements the counter.
    - When the counter reaches 1 on an edge -> RESP.
  - RESP: out_valid_o=1; result_o, zero_o and branch_taken_o are held stable until out_ready_i.
    - in_ready_o = out_ready_i.
    - Simultaneous out_ready_i && in_valid_i: retire the old result and accept the new op in the same edge; next state is RESP or SHIFT per the new op.
    - out_ready_i without a new op -> IDLE, out_valid_o=0.
- Latency, counted from the accept edge N:
  - non-shift: out_valid_o high after edge N.
  - shift by k>0: out_valid_o high after edge N+k.
- Throughput: one non-shift op per cycle while out_ready_i=1.
- Inputs are sampled only on the accept edge. Operand changes afterwards have no effect.
- in_valid_i while in_ready_o=0: not accepted; the source holds its inputs.

Optional Feature:
- Macro ALU_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter, the SHIFT state and counter are removed, and every op has 1-cycle latency.
- Undefined: iterative shifting as above, k cycles for a shift of k.

Test Plan:
- ADD a=0x7FFFFFFF b=1, then SUB a=5 b=7 (ctrl 1000), out_ready=1:
  - results 0x80000000 then 0xFFFFFFFE.
  - back-to-back out_valid, in_ready held 1.
- SRA a=0x80000000 b=4 (ctrl 1110): in_ready low 4 cycles; result 0xF8000000 valid after edge N+4. SRL of the same gives 0x08000000.
- SLL with b=0x20, shamt 0: 1-cycle latency, result=a.
- SLT a=-1 b=1 -> 1; SLTU with the same operands -> 0.
- Branch mode:
  - BLT a=0xFFFFFFFF b=0 -> taken=1.
  - BGEU with the same operands -> taken=1.
  - BEQ a=b=9 -> taken=1, zero_o=1.
  - funct3 010 -> taken=0.
- Back-pressure and reset:
  - out_ready=0 for 3 cycles: result held, no new op accepted.
  - rst asserted mid-SHIFT: next cycle out_valid=0, in_ready=1, result_o=0.
